// File: rtl/fp_adder_arbiter_pkg.sv
// fp_adder_arbiter_pkg: shared state encoding, clog2 and adder NaN builder for fp_adder_arbiter
package fp_adder_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT, FLUSH} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int exp_width(input int n);
    return n == 64 ? 11 : n == 16 ? 5 : 8;
  endfunction
  // sign, every exponent bit and the fraction MSB set: the adder's quiet NaN
  function automatic logic [63:0] nan_bits(input int n, input int ew);
    logic [63:0] r = '0;
    for (int i = 0; i <= ew + 1; i++) r[n-1-i] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// rr_arbiter: combinational find-first-set over req starting at ptr, one-hot grant plus index
module rr_arbiter import fp_adder_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  // scan offsets from farthest to nearest so the first valid index at or after ptr wins
  always_comb begin
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      idx = req[(int'(ptr) + k) % NREQ] ? IW'((int'(ptr) + k) % NREQ) : idx;
    grant = '0;
    grant[idx] = |req;
  end
endmodule

// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: round-robin sharing of one strobe-protocol fp adder; FP_ADDER_ARB_TIMEOUT_EN adds a WAIT watchdog
module fp_adder_arbiter import fp_adder_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  parameter int n = 32,
  parameter int TIMEOUT = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*n-1:0]      req_a,
  input  logic [NREQ*n-1:0]      req_b,
  output logic [NREQ-1:0]        req_accept,
  output logic                   resp_valid,
  output logic [clog2(NREQ)-1:0] resp_id,
  output logic [n-1:0]           resp_z,
  output logic                   resp_err,
  output logic [n-1:0]           add_a,
  output logic [n-1:0]           add_b,
  output logic                   add_a_stb,
  output logic                   add_b_stb,
  input  logic [n-1:0]           add_z,
  input  logic                   add_z_stb,
  output logic                   add_rst
);
  localparam int IW = clog2(NREQ);
  state_t state;
  logic [IW-1:0] rr_ptr, cur_id, gidx;
  logic [NREQ-1:0] grant;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(gidx)
  );
  assign add_a_stb = state == SEND_A;
  assign add_b_stb = state == SEND_B;
`ifdef FP_ADDER_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT + 1);
  localparam logic [n-1:0] NAN_Z = n'(nan_bits(n, exp_width(n)));
  logic [CW-1:0] cnt;
  assign add_rst = state == FLUSH;
`else
  localparam int unused_timeout = TIMEOUT;
  assign add_rst = 1'b0;
`endif
  // grant, operand capture, strobe sequencing and result return; only one operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      add_a      <= '0;
      add_b      <= '0;
      req_accept <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_z     <= '0;
      resp_id    <= '0;
`ifdef FP_ADDER_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      req_accept <= '0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          add_a      <= req_a[int'(gidx)*n +: n];
          add_b      <= req_b[int'(gidx)*n +: n];
          cur_id     <= gidx;
          rr_ptr     <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
          req_accept <= grant;
          state      <= SEND_A;
        end
        SEND_A: state <= SEND_B;
        SEND_B: begin
          state <= WAIT;
`ifdef FP_ADDER_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          if (add_z_stb) begin
            resp_z     <= add_z;
            resp_id    <= cur_id;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            state      <= IDLE;
          end
`ifdef FP_ADDER_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            resp_z     <= NAN_Z;
            resp_id    <= cur_id;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= FLUSH;
          end else cnt <= cnt + 1'b1;
`endif
        end
        FLUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
